spi_byte_feeder: RTL and testbench
==================================

Name: spi_byte_feeder

Overview:
- Byte-buffering front end for the SPI byte transmitter. It accepts command/data bytes from the processor-side register interface into a small FIFO.
- It drains the FIFO one byte at a time over the transmitter's tx_en / data_in / tx_done handshake.
- It presents a per-byte data/command flag to the display so it stays aligned with the byte on the wire.

Parameters:
DEPTH, 16, FIFO entries (power of two, >=2)
ADDR_W, 4, log2(DEPTH)
GAP_CYCLES, 2, idle clocks inserted after each tx_done rise before the next launch (0 allowed)
ARM_TIMEOUT, 8, clocks to wait for spi_done to fall after a launch before flagging an error

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
wr_en  in  1  push request
wr_data  in  8  byte to push
wr_dc  in  1  D/C flag stored with byte (1=data, 0=command)
flush  in  1  synchronous FIFO clear
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
level  out  ADDR_W+1  current entry count
overflow  out  1  one-cycle pulse: push dropped
timeout_err  out  1  one-cycle pulse: ARM timeout expired
busy  out  1  FIFO non-empty or FSM not IDLE
spi_tx_en  out  1  launch strobe to transmitter (one cycle)
spi_data  out  8  byte to transmitter, held stable until next launch
spi_done  in  1  transmitter idle/done (1 = idle)
oled_dc  out  1  D/C of byte in flight, held with spi_data

Behaviour:
- All state updates on posedge clk. Reset is sampled only at the edge.
- Reset values:
  - spi_tx_en=0, spi_data=0, oled_dc=0
  - full=0, empty=1, level=0
  - overflow=0, timeout_err=0, busy=0
  - FSM=IDLE, pointers=0
- Reset mid-transfer abandons the byte. spi_tx_en is never reasserted until the FSM returns to IDLE and spi_done=1.
- FIFO: 9-bit entries {dc, data}, registered count; full/empty/level derived from the count.
  - Push when wr_en && !full. Write pointer wraps DEPTH-1 -> 0.
  - wr_en while full (judged on pre-edge count): byte dropped, overflow=1 for one cycle. Applies even if a pop happens the same edge.
  - Push and pop on the same edge: level unchanged, both pointers advance.
  - flush: pointers and level go to 0 and any same-edge push is discarded. An in-flight byte and the FSM are unaffected.
- FSM states: IDLE, ARM, XFER, GAP.
  - IDLE: if !empty && spi_done, then at that edge:
    - spi_tx_en<=1
    - {oled_dc, spi_data}<=FIFO head
    - pop
    - arm counter<=0
    - go to ARM
    Otherwise stay in IDLE.
  - ARM: spi_tx_en<=0 (strobe is exactly one cycle wide).
    - If spi_done==0: go to XFER.
    - Else if the arm counter reaches ARM_TIMEOUT-1: timeout_err=1 for one cycle, go to IDLE. The byte is lost and not re-queued.
    - Else increment the arm counter.
  - XFER: wait for spi_done==1, then load the gap counter and go to GAP. If GAP_CYCLES=0, go directly to IDLE.
  - GAP: count GAP_CYCLES clocks, then go to IDLE.
- Latency:
  - wr_en sampled at edge k into an empty FIFO with spi_done=1 and FSM in IDLE: spi_tx_en is high between edges k+1 and k+2.
  - Back-to-back bytes: the next spi_tx_en rises GAP_CYCLES+1 edges after the edge where XFER sees spi_done=1.
- spi_data and oled_dc change only at a launch edge.
- busy is combinational: !empty || state!=IDLE.

Test Plan:
- Reset, then push 0xAE (dc=0): spi_tx_en pulses exactly one cycle with spi_data=0xAE, oled_dc=0. level 1->0 at the launch edge. With the transmitter model, busy clears GAP_CYCLES+1 edges after tx_done rises.
- Push 0x01,0x02,0x03 (dc=1,1,0) back-to-back: three launches in order with matching oled_dc. Each launch occurs only after spi_done rose and 2 gap clocks elapsed. No launch while spi_done=0.
- Push 17 bytes with the transmitter held busy: full=1 at level=16, 17th push gives overflow=1 for one cycle. Drained sequence is the first 16 bytes, and pointers wrap correctly.
- Hold spi_done=1 permanently (no transmitter response) after a push of 0x55: timeout_err pulses 8 cycles after the ARM entry, FSM returns to IDLE, the next byte launches normally.
- Push 4 bytes, assert flush while the first is in XFER: the in-flight byte completes, level=0, empty=1, and no further launches.
- Assert reset low for one edge during XFER: all outputs return to reset values on that edge, the FIFO is empty, and no spurious spi_tx_en appears afterwards.

Source files
------------

// File: rtl/spi_byte_feeder_if.sv
// Processor write port and transmitter handshake
// for the SPI byte feeder.
interface spi_byte_feeder_if #(
  parameter int ADDR_W = 4
);
  logic            wr_en;
  logic [7:0]      wr_data;
  logic            wr_dc;
  logic            flush;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] level;
  logic            overflow;
  logic            timeout_err;
  logic            busy;
  logic            spi_tx_en;
  logic [7:0]      spi_data;
  logic            spi_done;
  logic            oled_dc;

  modport slave (
    input  wr_en,
    input  wr_data,
    input  wr_dc,
    input  flush,
    input  spi_done,
    output full,
    output empty,
    output level,
    output overflow,
    output timeout_err,
    output busy,
    output spi_tx_en,
    output spi_data,
    output oled_dc
  );

  modport master (
    output wr_en,
    output wr_data,
    output wr_dc,
    output flush,
    output spi_done,
    input  full,
    input  empty,
    input  level,
    input  overflow,
    input  timeout_err,
    input  busy,
    input  spi_tx_en,
    input  spi_data,
    input  oled_dc
  );
endinterface

// File: rtl/spi_byte_feeder.sv
// Byte FIFO plus launch FSM feeding the SPI byte
// transmitter, carrying the OLED D/C flag per byte.
module spi_byte_feeder #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int ARM_TIMEOUT = 8
) (
  input logic              clk,
  input logic              reset,
  spi_byte_feeder_if.slave bus
);

  localparam int AW =
    (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam int GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int CW = ADDR_W + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] ARM_LAST =
    AW'((ARM_TIMEOUT > 0) ? ARM_TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] GAP_LOAD =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    XFER,
    GAP
  } state_t;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CW-1:0]     count;
  state_t            state;
  logic [AW-1:0]     arm_cnt;
  logic [GW-1:0]     gap_cnt;

  logic       full;
  logic       empty;
  logic       push;
  logic       launch;
  logic       overflow_q;
  logic       timeout_q;
  logic       tx_en_q;
  logic [7:0] data_q;
  logic       dc_q;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign push   = bus.wr_en && !full;
  assign launch = (state == IDLE) && !empty
               && bus.spi_done;
  assign head   = mem[rd_ptr];

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.level       = count;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = timeout_q;
  assign bus.busy        = !empty || (state != IDLE);
  assign bus.spi_tx_en   = tx_en_q;
  assign bus.spi_data    = data_q;
  assign bus.oled_dc     = dc_q;

  // Storage has no reset; only pointers and count matter.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem[wr_ptr] <= '{dc: bus.wr_dc, data: bus.wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= bus.wr_en && full;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
        end
        if (launch) begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
        end
        case ({push, launch})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Launch data and D/C only move at a launch edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      tx_en_q   <= 1'b0;
      data_q    <= 8'h00;
      dc_q      <= 1'b0;
      arm_cnt   <= '0;
      gap_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      tx_en_q   <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch) begin
            tx_en_q <= 1'b1;
            data_q  <= head.data;
            dc_q    <= head.dc;
            arm_cnt <= '0;
            state   <= ARM;
          end
        end
        ARM: begin
          if (!bus.spi_done) begin
            state <= XFER;
          end else if (arm_cnt == ARM_LAST) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            arm_cnt <= arm_cnt + AW'(1);
          end
        end
        XFER: begin
          if (bus.spi_done) begin
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_feeder.sv
// Directed bench for spi_byte_feeder with a small
// transmitter model answering the launch strobe.
module tb_spi_byte_feeder;

  localparam int XF = 3;
  localparam logic [19:0] RST_V =
    {1'b0, 8'h00, 1'b0, 1'b0, 1'b1,
     5'd0, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  spi_byte_feeder_if #(.ADDR_W(4)) bus ();

  spi_byte_feeder #(
    .DEPTH(16),
    .ADDR_W(4),
    .GAP_CYCLES(2),
    .ARM_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int viol        = 0;
  int cyc         = 0;
  int xfer_left   = 0;
  bit respond     = 1'b1;
  bit hold        = 1'b0;
  bit txen_prev   = 1'b0;
  logic done_at_edge;
  logic [8:0] log_q [$];
  int         log_t [$];

  // Transmitter: drops done one step after seeing the
  // strobe, stays busy XF clocks, then raises it again.
  always @(posedge clk) begin
    bit launched;
    cyc++;
    done_at_edge = bus.spi_done;
    launched = (bus.spi_tx_en === 1'b1);
    if (launched) begin
      log_q.push_back({bus.oled_dc, bus.spi_data});
      log_t.push_back(cyc);
    end
    #1;
    if (launched && respond) xfer_left = XF;
    else if (xfer_left > 0) xfer_left--;
    bus.spi_done = (xfer_left == 0) && !hold;
  end

  always @(negedge clk) begin
    if (bus.spi_tx_en === 1'b1 &&
        (done_at_edge !== 1'b1 || txen_prev)) viol++;
    txen_prev = (bus.spi_tx_en === 1'b1);
  end

  function automatic logic [19:0] outs();
    return {bus.spi_tx_en, bus.spi_data, bus.oled_dc,
            bus.full, bus.empty, bus.level,
            bus.overflow, bus.timeout_err, bus.busy};
  endfunction

  task automatic wait_idle(input int budget,
                           input string tag);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: busy=%b after %0d, need 0",
               tag, bus.busy, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (outs() !== RST_V) begin
      miscompares++;
      $display("FAIL reset_outs: got %h need %h",
               outs(), RST_V);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    bit found;
    log_q.delete(); log_t.delete();
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_data = 8'hAE; bus.wr_dc = 1'b0;
    @(negedge clk);
    bus.wr_en = 1'b0;
    vectors++;
    if ({bus.level, bus.busy, bus.spi_tx_en} !==
        {5'd1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_push: lvl=%0d busy=%b tx=%b need 1 1 0",
               bus.level, bus.busy, bus.spi_tx_en);
    end
    @(negedge clk);
    vectors++;
    if ({bus.spi_tx_en, bus.spi_data, bus.oled_dc, bus.level}
        !== {1'b1, 8'hAE, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL single_launch: tx=%b d=%h dc=%b lvl=%0d need 1 ae 0 0",
               bus.spi_tx_en, bus.spi_data, bus.oled_dc, bus.level);
    end
    @(negedge clk);
    vectors++;
    if (bus.spi_tx_en !== 1'b0) begin
      miscompares++;
      $display("FAIL single_strobe_width: tx=%b need 0",
               bus.spi_tx_en);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.spi_done === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL single_done: done=%b need 1", bus.spi_done);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_gap_busy: busy=%b need 1", bus.busy);
    end
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_busy_clear: busy=%b need 0", bus.busy);
    end
    vectors++;
    if (log_q.size() != 1 || log_q[0] !== 9'h0AE) begin
      miscompares++;
      $display("FAIL single_log: n=%0d need 1 entry 0ae",
               log_q.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp [3];
    exp[0] = 9'h101; exp[1] = 9'h102; exp[2] = 9'h003;
    log_q.delete(); log_t.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_data = exp[i][7:0];
      bus.wr_dc   = exp[i][8];
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_idle(100, "b2b");
    vectors++;
    if (log_q.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d need 3", log_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (log_q[i] !== exp[i]) begin
          miscompares++;
          $display("FAIL b2b_byte%0d: got %h need %h",
                   i, log_q[i], exp[i]);
        end
      end
      vectors++;
      if (log_t[1] - log_t[0] != 8 ||
          log_t[2] - log_t[1] != 8) begin
        miscompares++;
        $display("FAIL b2b_spacing: got %0d,%0d need 8,8",
                 log_t[1] - log_t[0], log_t[2] - log_t[1]);
      end
    end
  endtask

  task automatic test_overflow;
    hold = 1'b1;
    repeat (2) @(negedge clk);
    log_q.delete(); log_t.delete();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        vectors++;
        if ({bus.level, bus.full, bus.overflow} !==
            {5'd16, 1'b1, 1'b0}) begin
          miscompares++;
          $display("FAIL ovf_full: lvl=%0d full=%b ovf=%b need 16 1 0",
                   bus.level, bus.full, bus.overflow);
        end
      end
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(16 + i);
      bus.wr_dc   = i[0];
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    vectors++;
    if ({bus.overflow, bus.level} !== {1'b1, 5'd16}) begin
      miscompares++;
      $display("FAIL ovf_pulse: ovf=%b lvl=%0d need 1 16",
               bus.overflow, bus.level);
    end
    @(negedge clk);
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: ovf=%b need 0", bus.overflow);
    end
    hold = 1'b0;
    wait_idle(400, "ovf");
    vectors++;
    if (log_q.size() != 16) begin
      miscompares++;
      $display("FAIL ovf_count: got %0d need 16", log_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        vectors++;
        if (log_q[i] !== {i[0], 8'(16 + i)}) begin
          miscompares++;
          $display("FAIL ovf_byte%0d: got %h need %h",
                   i, log_q[i], {i[0], 8'(16 + i)});
        end
      end
    end
  endtask

  task automatic test_timeout;
    bit early;
    respond = 1'b0;
    log_q.delete(); log_t.delete();
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_data = 8'h55; bus.wr_dc = 1'b0;
    @(negedge clk);
    bus.wr_en = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.spi_tx_en, bus.spi_data} !== {1'b1, 8'h55}) begin
      miscompares++;
      $display("FAIL to_launch: tx=%b d=%h need 1 55",
               bus.spi_tx_en, bus.spi_data);
    end
    early = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (bus.timeout_err !== 1'b0) early = 1'b1;
    end
    vectors++;
    if (early) begin
      miscompares++;
      $display("FAIL to_early: timeout_err=1 need 0");
    end
    @(negedge clk);
    vectors++;
    if ({bus.timeout_err, bus.busy} !== {1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL to_pulse: to=%b busy=%b need 1 0",
               bus.timeout_err, bus.busy);
    end
    @(negedge clk);
    vectors++;
    if (bus.timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL to_width: to=%b need 0", bus.timeout_err);
    end
    respond = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_data = 8'h66; bus.wr_dc = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.spi_tx_en, bus.spi_data, bus.oled_dc} !==
        {1'b1, 8'h66, 1'b1}) begin
      miscompares++;
      $display("FAIL to_relaunch: tx=%b d=%h dc=%b need 1 66 1",
               bus.spi_tx_en, bus.spi_data, bus.oled_dc);
    end
    wait_idle(100, "to");
  endtask

  task automatic test_flush;
    log_q.delete(); log_t.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'hA0 + i);
      bus.wr_dc   = 1'b0;
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    vectors++;
    if (bus.level !== 5'd3) begin
      miscompares++;
      $display("FAIL flush_pre: lvl=%0d need 3", bus.level);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    vectors++;
    if ({bus.level, bus.empty, bus.busy} !==
        {5'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL flush_post: lvl=%0d empty=%b busy=%b need 0 1 1",
               bus.level, bus.empty, bus.busy);
    end
    wait_idle(100, "flush");
    repeat (20) @(negedge clk);
    vectors++;
    if (log_q.size() != 1 || log_q[0] !== 9'h0A0) begin
      miscompares++;
      $display("FAIL flush_log: n=%0d need 1 entry 0a0",
               log_q.size());
    end
  endtask

  task automatic test_reset_mid;
    log_q.delete(); log_t.delete();
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_data = 8'h77; bus.wr_dc = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    vectors++;
    if (outs() !== RST_V) begin
      miscompares++;
      $display("FAIL rstmid_outs: got %h need %h",
               outs(), RST_V);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (log_q.size() != 1) begin
      miscompares++;
      $display("FAIL rstmid_spurious: launches=%0d need 1",
               log_q.size());
    end
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_data = 8'h88; bus.wr_dc = 1'b0;
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_idle(100, "rstmid");
    vectors++;
    if (log_q.size() != 2 || log_q[1] !== 9'h088) begin
      miscompares++;
      $display("FAIL rstmid_resume: n=%0d need 2 last 088",
               log_q.size());
    end
  endtask

  task automatic test_protocol;
    vectors++;
    if (viol != 0) begin
      miscompares++;
      $display("FAIL protocol: bad strobes=%0d need 0", viol);
    end
  endtask

  initial begin
    reset       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.wr_dc   = 1'b0;
    bus.flush   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
